// File: rtl/ram_pg_init_ctrl.sv
// Power-gate sequencer and write-port master for one power-gated 2R1W RAM bank.
// After reset or ungating it rewrites every entry with the reset pattern, then hands the write port to the client.
`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 1
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 2
`endif

module ram_pg_init_ctrl #(
    parameter int DEPTH       = 64,
    parameter int INDEX       = 6,
    parameter int WIDTH       = 32,
    parameter int RESET_VAL   = `RAM_RESET_ZERO,
    parameter int SEQ_START   = 0,
    parameter int WAKE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gate_req_i,
    output logic             gate_ack_o,
    output logic             ready_o,
    input  logic             we_i,
    input  logic [INDEX-1:0] addrWr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             pwrGate_o,
    output logic             ramWe_o,
    output logic [INDEX-1:0] ramAddrWr_o,
    output logic [WIDTH-1:0] ramData_o
);

    localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WCW-1:0]   WAKE_LAST = WCW'(WAKE_CYCLES - 1);
    localparam logic [INDEX-1:0] INIT_LAST = INDEX'(DEPTH - 1);
    localparam bit DO_INIT = (RESET_VAL == `RAM_RESET_ZERO) || (RESET_VAL == `RAM_RESET_SEQ);
    localparam bit DO_SEQ  = (RESET_VAL == `RAM_RESET_SEQ);

    typedef enum logic [1:0] {
        S_WAKE  = 2'd0,
        S_INIT  = 2'd1,
        S_READY = 2'd2,
        S_GATED = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WCW-1:0]   r_wake_cnt;
    logic [WCW-1:0]   w_wake_cnt_nxt;
    logic [INDEX-1:0] r_init_cnt;
    logic [INDEX-1:0] w_init_cnt_nxt;
    logic [WIDTH-1:0] w_init_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_WAKE;
            r_wake_cnt <= '0;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wake_cnt <= w_wake_cnt_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // Sequence pattern is the entry index offset by SEQ_START, wrapped to the data width.
    assign w_init_data = DO_SEQ ? (WIDTH'(SEQ_START) + WIDTH'(r_init_cnt)) : '0;

    always_comb begin
        w_next         = r_state;
        w_wake_cnt_nxt = '0;
        w_init_cnt_nxt = '0;
        ramWe_o        = 1'b0;
        ramAddrWr_o    = '0;
        ramData_o      = '0;
        case (r_state)
            S_WAKE: begin
                if (r_wake_cnt == WAKE_LAST) begin
                    w_next = DO_INIT ? S_INIT : S_READY;
                end else begin
                    w_wake_cnt_nxt = r_wake_cnt + 1'b1;
                end
            end
            S_INIT: begin
                ramWe_o     = 1'b1;
                ramAddrWr_o = r_init_cnt;
                ramData_o   = w_init_data;
                // gate_req_i and the client port are deliberately ignored until the sweep ends.
                if (r_init_cnt == INIT_LAST) begin
                    w_next = S_READY;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            S_READY: begin
                ramWe_o     = we_i;
                ramAddrWr_o = addrWr_i;
                ramData_o   = data_i;
                if (gate_req_i) begin
                    w_next = S_GATED;
                end
            end
            S_GATED: begin
                if (!gate_req_i) begin
                    w_next = S_WAKE;
                end
            end
            default: w_next = S_WAKE;
        endcase
    end

    // Status flags decode only the state register so they never glitch.
    assign ready_o    = (r_state == S_READY);
    assign gate_ack_o = (r_state == S_GATED);
    assign pwrGate_o  = (r_state == S_GATED);

endmodule

// File: tb/tb_ram_pg_init_ctrl.sv
// Self-checking bench for ram_pg_init_ctrl: three configurations (zero init, sequence init, no init)
// compared cycle by cycle against a timeline model plus a behavioural bank attached to each write port.
`timescale 1ns/1ps

module tb_ram_pg_init_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [3];
    logic        gate_req [3];
    logic        we_in    [3];
    logic [5:0]  addr_in  [3];
    logic [31:0] data_in  [3];

    logic a_ack, a_rdy, a_pg, a_we;
    logic [5:0] a_addr;
    logic [31:0] a_data;
    logic b_ack, b_rdy, b_pg, b_we;
    logic [3:0] b_addr;
    logic [31:0] b_data;
    logic c_ack, c_rdy, c_pg, c_we;
    logic [5:0] c_addr;
    logic [31:0] c_data;

    ram_pg_init_ctrl u_a (
        .clk(clk), .reset(rst_n[0]), .gate_req_i(gate_req[0]), .gate_ack_o(a_ack), .ready_o(a_rdy),
        .we_i(we_in[0]), .addrWr_i(addr_in[0]), .data_i(data_in[0]), .pwrGate_o(a_pg),
        .ramWe_o(a_we), .ramAddrWr_o(a_addr), .ramData_o(a_data));

    ram_pg_init_ctrl #(.DEPTH(10), .INDEX(4), .WIDTH(32), .RESET_VAL(2), .SEQ_START(100), .WAKE_CYCLES(4)) u_b (
        .clk(clk), .reset(rst_n[1]), .gate_req_i(gate_req[1]), .gate_ack_o(b_ack), .ready_o(b_rdy),
        .we_i(we_in[1]), .addrWr_i(addr_in[1][3:0]), .data_i(data_in[1]), .pwrGate_o(b_pg),
        .ramWe_o(b_we), .ramAddrWr_o(b_addr), .ramData_o(b_data));

    ram_pg_init_ctrl #(.DEPTH(64), .INDEX(6), .WIDTH(32), .RESET_VAL(3), .SEQ_START(0), .WAKE_CYCLES(3)) u_c (
        .clk(clk), .reset(rst_n[2]), .gate_req_i(gate_req[2]), .gate_ack_o(c_ack), .ready_o(c_rdy),
        .we_i(we_in[2]), .addrWr_i(addr_in[2]), .data_i(data_in[2]), .pwrGate_o(c_pg),
        .ramWe_o(c_we), .ramAddrWr_o(c_addr), .ramData_o(c_data));

    // Behavioural banks: gating wipes contents to unknown, writes land on the rising edge.
    logic [31:0] bank [3][64];
    always @(posedge clk) begin
        if (a_pg) begin
            for (int i = 0; i < 64; i++) bank[0][i] <= 'x;
        end else if (a_we) bank[0][a_addr] <= a_data;
        if (b_pg) begin
            for (int i = 0; i < 64; i++) bank[1][i] <= 'x;
        end else if (b_we) bank[1][b_addr] <= b_data;
        if (c_pg) begin
            for (int i = 0; i < 64; i++) bank[2][i] <= 'x;
        end else if (c_we) bank[2][c_addr] <= c_data;
    end

    // Timeline model: n = cycles since the wake sequence started.
    int W    [3] = '{4, 4, 3};
    int D    [3] = '{64, 10, 0};
    int MODE [3] = '{1, 2, 3};
    int SEQ0 [3] = '{0, 100, 0};
    int n    [3];
    bit gated[3];
    logic [31:0] em [3][64];

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] pat(int id, int k);
        if (MODE[id] == 2) return 32'(SEQ0[id] + k);
        return 32'h0;
    endfunction

    function automatic logic [5:0] amask(int id);
        return (id == 1) ? (addr_in[id] & 6'h0F) : addr_in[id];
    endfunction

    // Layout: {pwrGate, gate_ack, ready, we, addr[5:0], data[31:0]}
    function automatic logic [41:0] exp_vec(int id);
        logic [41:0] v;
        v = '0;
        if (!rst_n[id]) v = '0;
        else if (gated[id]) v[41:40] = 2'b11;
        else if (n[id] < W[id]) v = '0;
        else if (n[id] < W[id] + D[id]) begin
            v[38]    = 1'b1;
            v[37:32] = 6'(n[id] - W[id]);
            v[31:0]  = pat(id, n[id] - W[id]);
        end else begin
            v[39]    = 1'b1;
            v[38]    = we_in[id];
            v[37:32] = amask(id);
            v[31:0]  = data_in[id];
        end
        return v;
    endfunction

    function automatic logic [41:0] got_vec(int id);
        case (id)
            0:       return {a_pg, a_ack, a_rdy, a_we, a_addr, a_data};
            1:       return {b_pg, b_ack, b_rdy, b_we, 2'b00, b_addr, b_data};
            default: return {c_pg, c_ack, c_rdy, c_we, c_addr, c_data};
        endcase
    endfunction

    task automatic advance();
        for (int id = 0; id < 3; id++) begin
            if (!rst_n[id]) begin
                n[id] = 0;
                gated[id] = 1'b0;
            end else if (gated[id]) begin
                for (int k = 0; k < 64; k++) em[id][k] = 'x;
                if (!gate_req[id]) begin
                    gated[id] = 1'b0;
                    n[id] = 0;
                end
            end else if (n[id] >= W[id] + D[id]) begin
                if (we_in[id]) em[id][amask(id)] = data_in[id];
                if (gate_req[id]) gated[id] = 1'b1;
            end else begin
                if (n[id] >= W[id]) em[id][n[id] - W[id]] = pat(id, n[id] - W[id]);
                n[id]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_client(int id);
        we_in[id]   = 1'($urandom_range(0, 1));
        addr_in[id] = (id == 1) ? 6'($urandom_range(0, 9)) : 6'($urandom_range(0, 63));
        data_in[id] = $urandom;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int id = 0; id < 3; id++) begin
                checks++;
                if (got_vec(id) !== 42'h0) begin
                    errors++;
                    $display("FAIL reset dut=%0d got=%h exp=0", id, got_vec(id));
                end
            end
            advance();
        end
    endtask

    task automatic test_init_zero();
        rst_n[0] = 1'b1;
        for (int i = 0; i < 70; i++) begin
            #1;
            checks++;
            if (got_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL init_zero cyc=%0d got=%h exp=%h", i, got_vec(0), exp_vec(0));
            end
            if (i == 67 || i == 68) begin
                checks++;
                if (a_rdy !== (i == 68)) begin
                    errors++;
                    $display("FAIL init_zero_ready cyc=%0d got=%b exp=%b", i, a_rdy, (i == 68));
                end
            end
            advance();
        end
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (bank[0][k] !== 32'h0) begin
                errors++;
                $display("FAIL init_zero_bank addr=%0d got=%h exp=0", k, bank[0][k]);
            end
        end
    endtask

    task automatic test_client_random();
        gate_req[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rand_client(0);
            #1;
            checks++;
            if (got_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL client cyc=%0d got=%h exp=%h", i, got_vec(0), exp_vec(0));
            end
            advance();
        end
        we_in[0] = 1'b0;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (bank[0][k] !== em[0][k]) begin
                errors++;
                $display("FAIL client_bank addr=%0d got=%h exp=%h", k, bank[0][k], em[0][k]);
            end
        end
    endtask

    task automatic test_gate_with_write();
        we_in[0] = 1'b1; addr_in[0] = 6'd5; data_in[0] = 32'hA5; gate_req[0] = 1'b1;
        #1;
        checks++;
        if (got_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL gate_write cyc=0 got=%h exp=%h", got_vec(0), exp_vec(0));
        end
        advance();
        we_in[0] = 1'b0;
        #1;
        checks++;
        if ({a_pg, a_ack, a_rdy, a_we} !== 4'b1100) begin
            errors++;
            $display("FAIL gate_write_flags got=%b exp=1100", {a_pg, a_ack, a_rdy, a_we});
        end
        checks++;
        if (bank[0][5] !== 32'hA5) begin
            errors++;
            $display("FAIL gate_write_bank got=%h exp=000000a5", bank[0][5]);
        end
    endtask

    task automatic test_ungate();
        int hold;
        hold = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++) begin
            advance();
            #1;
            checks++;
            if (got_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL gated_hold cyc=%0d got=%h exp=%h", i, got_vec(0), exp_vec(0));
            end
        end
        gate_req[0] = 1'b0;
        advance();
        for (int i = 0; i < 70; i++) begin
            rand_client(0);
            if (!(n[0] >= W[0] + D[0])) we_in[0] = 1'b0;
            #1;
            checks++;
            if (got_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL ungate cyc=%0d got=%h exp=%h", i, got_vec(0), exp_vec(0));
            end
            if (i == 0) begin
                checks++;
                if (a_pg !== 1'b0) begin
                    errors++;
                    $display("FAIL ungate_pg got=%b exp=0", a_pg);
                end
            end
            we_in[0] = 1'b0;
            advance();
        end
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (bank[0][k] !== 32'h0) begin
                errors++;
                $display("FAIL ungate_bank addr=%0d got=%h exp=0", k, bank[0][k]);
            end
        end
    endtask

    task automatic gate_cycle(int id);
        we_in[id] = 1'b0;
        gate_req[id] = 1'b1;
        advance();
        gate_req[id] = 1'b0;
        advance();
    endtask

    task automatic test_gate_during_init();
        bit armed = 1'b0;
        int rdy_cycles = 0;
        gate_cycle(0);
        for (int i = 0; i < 100; i++) begin
            if (!armed && !gated[0] && n[0] == W[0] + 20) armed = 1'b1;
            gate_req[0] = armed;
            #1;
            checks++;
            if (got_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL gate_in_init cyc=%0d got=%h exp=%h", i, got_vec(0), exp_vec(0));
            end
            if (a_rdy === 1'b1) rdy_cycles++;
            advance();
        end
        checks++;
        if (rdy_cycles != 1 || a_pg !== 1'b1) begin
            errors++;
            $display("FAIL gate_in_init_ready got=%0d/%b exp=1/1", rdy_cycles, a_pg);
        end
        gate_req[0] = 1'b0;
        advance();
    endtask

    task automatic test_reset_mid_init();
        for (int i = 0; i < W[0] + 30; i++) advance();
        rst_n[0] = 1'b0;
        #1;
        checks++;
        if (got_vec(0) !== 42'h0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", got_vec(0));
        end
        advance();
        advance();
        rst_n[0] = 1'b1;
        for (int i = 0; i < 70; i++) begin
            #1;
            checks++;
            if (got_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL reset_restart cyc=%0d got=%h exp=%h", i, got_vec(0), exp_vec(0));
            end
            if (i == 4) begin
                checks++;
                if ({a_we, a_addr} !== 7'b1_000000) begin
                    errors++;
                    $display("FAIL reset_restart_addr got=%b/%0d exp=1/0", a_we, a_addr);
                end
            end
            advance();
        end
    endtask

    task automatic test_seq();
        rst_n[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (got_vec(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL seq cyc=%0d got=%h exp=%h", i, got_vec(1), exp_vec(1));
            end
            if (i == 13 || i == 14) begin
                checks++;
                if (b_rdy !== (i == 14)) begin
                    errors++;
                    $display("FAIL seq_ready cyc=%0d got=%b exp=%b", i, b_rdy, (i == 14));
                end
            end
            advance();
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (bank[1][k] !== 32'(100 + k)) begin
                errors++;
                $display("FAIL seq_bank addr=%0d got=%0d exp=%0d", k, bank[1][k], 100 + k);
            end
        end
    endtask

    task automatic test_noinit();
        rst_n[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_client(2);
            #1;
            checks++;
            if (got_vec(2) !== exp_vec(2)) begin
                errors++;
                $display("FAIL noinit cyc=%0d got=%h exp=%h", i, got_vec(2), exp_vec(2));
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (c_rdy !== (i == 3)) begin
                    errors++;
                    $display("FAIL noinit_ready cyc=%0d got=%b exp=%b", i, c_rdy, (i == 3));
                end
            end
            advance();
        end
        we_in[2] = 1'b0;
    endtask

    task automatic test_random_gating();
        for (int i = 0; i < 900; i++) begin
            rand_client(0);
            if ($urandom_range(0, 19) == 0) gate_req[0] = ~gate_req[0];
            #1;
            checks++;
            if (got_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL random_gate cyc=%0d got=%h exp=%h", i, got_vec(0), exp_vec(0));
            end
            advance();
        end
        gate_req[0] = 1'b0;
        we_in[0] = 1'b0;
        for (int i = 0; i < 72; i++) advance();
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (bank[0][k] !== em[0][k]) begin
                errors++;
                $display("FAIL random_bank addr=%0d got=%h exp=%h", k, bank[0][k], em[0][k]);
            end
        end
    endtask

    initial begin
        for (int id = 0; id < 3; id++) begin
            rst_n[id] = 1'b0; gate_req[id] = 1'b0; we_in[id] = 1'b0;
            addr_in[id] = '0; data_in[id] = '0; n[id] = 0; gated[id] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_init_zero();
        test_client_random();
        test_gate_with_write();
        test_ungate();
        test_gate_during_init();
        test_reset_mid_init();
        test_seq();
        test_noinit();
        test_random_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
